// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
// Owns the HI/LO architectural registers. mult/multu/div/divu compute their
// 64-bit result when the op is accepted, keep it in a pending register, and
// commit it to HI/LO after a fixed number of busy cycles. mthi/mtlo write
// immediately. mfhi/mflo read back through the combinational MDUOut mux.

module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Arithmetic helpers, each returning {hi, lo}
    // ------------------------------------------------------------------

    // Signed 32x32 -> 64 product.
    function automatic logic [63:0] f_mult_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
    endfunction

    // Unsigned 32x32 -> 64 product.
    function automatic logic [63:0] f_mult_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Unsigned divide; divide-by-zero yields quotient all-ones, remainder = dividend.
    function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    // Signed divide on magnitudes: quotient truncates toward zero, remainder
    // follows the dividend's sign. The one overflowing case is pinned explicitly.
    function automatic logic [63:0] f_div_s(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q_u;
        logic [31:0] r_u;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] res;
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            res = {32'd0, 32'h8000_0000};
        end else begin
            q_u = mag_a / mag_b;
            r_u = mag_a % mag_b;
            q   = (a[31] ^ b[31]) ? (32'd0 - q_u) : q_u;
            r   = a[31] ? (32'd0 - r_u) : r_u;
            res = {r, q};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_r, state_n;
    logic [CNT_W-1:0]   cnt_r,   cnt_n;
    logic [63:0]        pend_r,  pend_n;
    logic [31:0]        hi_r,    hi_n;
    logic [31:0]        lo_r,    lo_n;
    logic               busy_r;
    logic [63:0]        calc_s;

    // Select the 64-bit result of the requested arithmetic op.
    always_comb begin
        calc_s = 64'd0;
        case (MDUOp)
            OP_MULT:  calc_s = f_mult_s(A, B);
            OP_MULTU: calc_s = f_mult_u(A, B);
            OP_DIV:   calc_s = f_div_s(A, B);
            OP_DIVU:  calc_s = f_div_u(A, B);
            default:  calc_s = 64'd0;
        endcase
    end

    // Next-state logic: accept ops in IDLE, count down and commit in RUN.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        pend_n  = pend_r;
        hi_n    = hi_r;
        lo_n    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            pend_n  = calc_s;
                            cnt_n   = MULT_LOAD;
                            state_n = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_n  = calc_s;
                            cnt_n   = DIV_LOAD;
                            state_n = ST_RUN;
                        end
                        OP_MTHI: hi_n = A;
                        OP_MTLO: lo_n = A;
                        OP_MFHI, OP_MFLO: begin
                            state_n = ST_IDLE;
                        end
                        default: begin
                            state_n = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is deliberately ignored here; the hazard unit should
                // never issue one, but a stray one must not disturb the op.
                if (cnt_r <= CNT_ONE) begin
                    hi_n    = pend_r[63:32];
                    lo_n    = pend_r[31:0];
                    cnt_n   = CNT_ZERO;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers; reset aborts any op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            pend_r  <= 64'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            pend_r  <= pend_n;
            hi_r    <= hi_n;
            lo_r    <= lo_n;
            busy_r  <= (state_n == ST_RUN);
        end
    end

    // Read-back mux for mfhi/mflo, same cycle as the op in E.
    always_comb begin
        MDUOut = 32'd0;
        case (MDUOp)
            OP_MFHI: MDUOut = hi_r;
            OP_MFLO: MDUOut = lo_r;
            default: MDUOut = 32'd0;
        endcase
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: table of directed vectors, hand-written multi-cycle
// sequences, and randomized ops checked against a plain-arithmetic model.

module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            4'd1: begin p = sa * sb; res = p; end
            4'd2: begin up = ua * ub; res = up; end
            4'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            end
            4'd4: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin up = ua / ub; res[31:0] = up[31:0]; up = ua % ub; res[63:32] = up[31:0]; end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Issue one op, count busy cycles, then check HI/LO.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc);
        int n;
        start = 1'b1; MDUOp = op; A = a; B = b;
        tick();
        start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            if (n == 2) begin
                chk({name, " HI held in RUN"}, HI, m_hi);
                chk({name, " LO held in RUN"}, LO, m_lo);
            end
            n++;
            tick();
        end
        chk({name, " busy cycles"}, 32'(n), 32'(ecyc));
        chk({name, " HI"}, HI, ehi);
        chk({name, " LO"}, LO, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        int n;
        logic [63:0] e;
        logic [3:0]  op;
        logic [31:0] ra, rb;

        vecs[0]  = '{"mult -3*5",      4'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        vecs[1]  = '{"multu ffffffff*2",4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{"div -7/2",       4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{"divu 7/0",       4'd4, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 10};
        vecs[4]  = '{"div overflow",   4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{"div 7/-2",       4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[6]  = '{"divu max/10",    4'd4, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 10};
        vecs[7]  = '{"mult min*min",   4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[8]  = '{"div 0/0",        4'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 10};
        vecs[9]  = '{"multu max*max",  4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[10] = '{"mult -1*-1",     4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5};

        reset = 1'b0; start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        #10 reset = 1'b1;
        tick();
        m_hi = 32'd0; m_lo = 32'd0;
        MDUOp = 4'd7; #1;
        chk("mfhi after reset", MDUOut, 32'd0);
        MDUOp = 4'd0;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // multu then mflo in the cycle right after busy drops
        run_op("multu for mflo", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5);
        start = 1'b1; MDUOp = 4'd8; #1;
        chk("mflo MDUOut", MDUOut, 32'hFFFF_FFFE);
        tick();
        start = 1'b0;
        chk("mflo no change HI", HI, m_hi);

        // mthi / mtlo on consecutive edges, no busy
        start = 1'b1; MDUOp = 4'd5; A = 32'h1234_5678;
        tick();
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi HI", HI, 32'h1234_5678);
        chk("mthi LO kept", LO, m_lo);
        MDUOp = 4'd6; A = 32'h9ABC_DEF0;
        tick();
        chk("mtlo busy", {31'd0, busy}, 32'd0);
        chk("mtlo LO", LO, 32'h9ABC_DEF0);
        chk("mtlo HI kept", HI, 32'h1234_5678);
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
        start = 1'b0; MDUOp = 4'd7; #1;
        chk("mfhi MDUOut", MDUOut, 32'h1234_5678);
        MDUOp = 4'd8; #1;
        chk("mflo MDUOut 2", MDUOut, 32'h9ABC_DEF0);
        MDUOp = 4'd5; #1;
        chk("MDUOut non-mf", MDUOut, 32'd0);
        start = 1'b1; MDUOp = 4'd12; A = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; MDUOp = 4'd0;
        chk("none op busy", {31'd0, busy}, 32'd0);
        chk("none op HI", HI, m_hi);
        chk("none op LO", LO, m_lo);

        // start while busy is ignored, including in the final RUN cycle
        start = 1'b1; MDUOp = 4'd1; A = 32'd7; B = 32'd6;
        tick();
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            if (n == 1 || n == 2) begin start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd3; end
            else if (n == 3) begin start = 1'b1; MDUOp = 4'd5; A = 32'hDEAD_0001; end
            else if (n == 4) begin start = 1'b1; MDUOp = 4'd6; A = 32'hDEAD_0002; end
            else begin start = 1'b0; MDUOp = 4'd0; end
            n++;
            tick();
        end
        start = 1'b0; MDUOp = 4'd0;
        chk("ignored start busy cycles", 32'(n), 32'd5);
        chk("ignored start HI", HI, 32'd0);
        chk("ignored start LO", LO, 32'd42);
        m_hi = 32'd0; m_lo = 32'd42;
        tick();
        chk("ignored start stays idle", {31'd0, busy}, 32'd0);

        // async reset in the middle of a div
        start = 1'b1; MDUOp = 4'd3; A = 32'd50; B = 32'd7;
        tick();
        start = 1'b0; MDUOp = 4'd0;
        repeat (3) tick();
        chk("pre-abort busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) tick();
        chk("no late commit busy", {31'd0, busy}, 32'd0);
        chk("no late commit HI", HI, 32'd0);
        chk("no late commit LO", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        // randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                3: ra = 32'h8000_0000;
                default: ra = ra;
            endcase
            if (op <= 4'd4) begin
                e = ref_op(op, ra, rb);
                run_op("random arith", op, ra, rb, e[63:32], e[31:0], (op <= 4'd2) ? 5 : 10);
            end else if (op == 4'd5) begin
                run_op("random mthi", op, ra, rb, ra, m_lo, 0);
            end else begin
                run_op("random mtlo", op, ra, rb, m_hi, ra, 0);
            end
            start = 1'($urandom_range(0, 1));
            MDUOp = 4'($urandom_range(7, 8));
            #1;
            chk("random mf MDUOut", MDUOut, (MDUOp == 4'd7) ? m_hi : m_lo);
            tick();
            start = 1'b0; MDUOp = 4'd0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
